// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and data access.
// Data has priority; a consecutive-grant counter bounds instruction starvation.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] scnt_q, scnt_d;
    logic       dreq_s;

    assign dreq_s = dREN | dWEN;

    // State and starvation counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            scnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    // Arbitration happens only in IDLE; a grant ends on completion or withdrawal
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            IDLE: begin
                if (iREN && (scnt_q == LIMIT)) begin
                    state_d = IACC;
                    scnt_d  = 4'd0;
                end else if (dreq_s) begin
                    state_d = DACC;
                    if (iREN) begin
                        scnt_d = (scnt_q == LIMIT) ? LIMIT : scnt_q + 4'd1;
                    end else begin
                        scnt_d = 4'd0;
                    end
                end else if (iREN) begin
                    state_d = IACC;
                    scnt_d  = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            IACC: begin
                if (ram_ready || !iREN) begin
                    state_d = IDLE;
                end else begin
                    state_d = IACC;
                end
            end
            DACC: begin
                if (ram_ready || !dreq_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DACC;
                end
            end
            default: begin
                state_d = IDLE;
                scnt_d  = 4'd0;
            end
        endcase
    end

    // RAM strobes follow the live request so a withdrawn grant issues nothing
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_q)
            IDLE: begin
                ramREN = 1'b0;
            end
            IACC: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~ram_ready;
            end
            DACC: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~ram_ready;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a grant-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = 32'd0;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = 32'd0;
    logic [31:0] dstore = 32'd0;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = 32'd0;
    logic        ram_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the RAM (0 none, 1 instruction, 2 data) and the run of data grants
    int m_owner = 0;
    int m_druns = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_owner <= 0;
            m_druns <= 0;
        end else if (m_owner == 0) begin
            if (iREN && m_druns >= 4) begin
                m_owner <= 1;
                m_druns <= 0;
            end else if (dREN || dWEN) begin
                m_owner <= 2;
                m_druns <= iREN ? ((m_druns + 1 > 4) ? 4 : m_druns + 1) : 0;
            end else if (iREN) begin
                m_owner <= 1;
                m_druns <= 0;
            end
        end else if (m_owner == 1) begin
            if (ram_ready || !iREN) m_owner <= 0;
        end else begin
            if (ram_ready || !(dREN || dWEN)) m_owner <= 0;
        end
    end

    // Every-cycle comparison of all outputs against the model's owner
    always @(negedge CLK) begin
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'd0; e_store = 32'd0;
        e_iw = 1'b1; e_dw = 1'b1;
        if (m_owner == 1) begin
            e_ren = iREN; e_addr = iaddr; e_iw = ~ram_ready;
        end else if (m_owner == 2) begin
            e_wen = dWEN; e_ren = dREN & ~dWEN; e_addr = daddr;
            e_store = dstore; e_dw = ~ram_ready;
        end
        check("m_ramREN",   {31'd0, ramREN}, {31'd0, e_ren});
        check("m_ramWEN",   {31'd0, ramWEN}, {31'd0, e_wen});
        check("m_ramaddr",  ramaddr, e_addr);
        check("m_ramstore", ramstore, e_store);
        check("m_iwait",    {31'd0, iwait}, {31'd0, e_iw});
        check("m_dwait",    {31'd0, dwait}, {31'd0, e_dw});
        check("m_iload",    iload, ramload);
        check("m_dload",    dload, ramload);
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    int seq [11];
    int exp_seq [11] = '{2, 0, 2, 0, 2, 0, 2, 0, 1, 0, 2};
    int d_before_i;

    initial begin
        #3;
        check("rst_ramREN", {31'd0, ramREN}, 32'd0);
        check("rst_iwait",  {31'd0, iwait}, 32'd1);
        check("rst_dwait",  {31'd0, dwait}, 32'd1);
        cyc(); cyc();
        RST = 1'b0;
        cyc();

        // Single instruction fetch
        iREN = 1'b1; iaddr = 32'h100;
        cyc(); #2;
        check("if_ramREN",  {31'd0, ramREN}, 32'd1);
        check("if_ramaddr", ramaddr, 32'h100);
        check("if_iwait_busy", {31'd0, iwait}, 32'd1);
        ram_ready = 1'b1; ramload = 32'hDEADBEEF;
        #1;
        check("if_iwait_done", {31'd0, iwait}, 32'd0);
        check("if_iload", iload, 32'hDEADBEEF);
        cyc();
        check("if_idle_after", {31'd0, ramREN}, 32'd0);
        iREN = 1'b0; ram_ready = 1'b0;
        cyc();

        // Simultaneous instruction + data write: data first
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h12345678;
        cyc(); #2;
        check("dw_ramWEN",   {31'd0, ramWEN}, 32'd1);
        check("dw_ramstore", ramstore, 32'h12345678);
        check("dw_ramaddr",  ramaddr, 32'h200);
        ram_ready = 1'b1;
        #1;
        check("dw_dwait_done", {31'd0, dwait}, 32'd0);
        cyc();
        dWEN = 1'b0; ram_ready = 1'b0;
        #2;
        check("dw_bubble", {31'd0, ramREN | ramWEN}, 32'd0);
        cyc(); #2;
        check("dw_then_i", ramaddr, 32'h100);
        check("dw_then_iREN", {31'd0, ramREN}, 32'd1);
        ram_ready = 1'b1;
        cyc();
        iREN = 1'b0; ram_ready = 1'b0;
        cyc();

        // Starvation bound with limit 4
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h300; iaddr = 32'h100; ram_ready = 1'b1;
        d_before_i = 0;
        for (int i = 0; i < 11; i++) begin
            cyc(); #2;
            if (ramREN && ramaddr == 32'h300) seq[i] = 2;
            else if (ramREN && ramaddr == 32'h100) seq[i] = 1;
            else seq[i] = 0;
        end
        for (int i = 0; i < 11; i++) begin
            check($sformatf("starve_seq%0d", i), seq[i], exp_seq[i]);
        end
        for (int i = 0; i < 8; i++) begin
            if (seq[i] == 2) d_before_i++;
        end
        check("starve_dgrants", d_before_i, 32'd4);
        cyc();
        iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
        cyc();

        // Read and write together is a write
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h400; dstore = 32'hA5A5A5A5;
        cyc(); #2;
        check("rw_ramWEN", {31'd0, ramWEN}, 32'd1);
        check("rw_ramREN", {31'd0, ramREN}, 32'd0);
        ram_ready = 1'b1;
        cyc();
        dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
        cyc();

        // Withdrawal of an instruction grant, pending data follows
        iREN = 1'b1; iaddr = 32'h500;
        cyc(); #2;
        check("wd_granted", {31'd0, ramREN}, 32'd1);
        iREN = 1'b0; dREN = 1'b1; daddr = 32'h600;
        #1;
        check("wd_strobe_drop", {31'd0, ramREN}, 32'd0);
        cyc(); #2;
        check("wd_idle", {31'd0, ramREN | ramWEN}, 32'd0);
        cyc(); #2;
        check("wd_d_ramREN",  {31'd0, ramREN}, 32'd1);
        check("wd_d_ramaddr", ramaddr, 32'h600);

        // Reset in the middle of a data access
        RST = 1'b1;
        #1;
        check("mr_ramREN",  {31'd0, ramREN}, 32'd0);
        check("mr_dwait",   {31'd0, dwait}, 32'd1);
        check("mr_ramaddr", ramaddr, 32'd0);
        cyc(); cyc();
        RST = 1'b0;
        cyc(); #2;
        check("mr_restart", {31'd0, ramREN}, 32'd1);
        check("mr_restart_dwait", {31'd0, dwait}, 32'd1);
        ram_ready = 1'b1; ramload = 32'hCAFEF00D;
        #1;
        check("mr_dwait_done", {31'd0, dwait}, 32'd0);
        check("mr_dload", dload, 32'hCAFEF00D);
        cyc();
        dREN = 1'b0; ram_ready = 1'b0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
